// File: rtl/sram_axi_pkg.sv
// sram_axi_pkg: shared FSM encoding, AXI constants and size mapping for sram_axi_master
package sram_axi_pkg;
    typedef enum logic [2:0] {IDLE, RADDR, RDATA, WREQ, WRESP} state_t;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    function automatic logic [2:0] axi_size(input logic [1:0] s);
        return (s == 2'd3) ? 3'b010 : {1'b0, s};
    endfunction
endpackage

// File: rtl/sram_axi_master.sv
// sram_axi_master: single-outstanding bridge from sram-like req/addr_ok/data_ok to single-beat AXI3 reads/writes
module sram_axi_master
    import sram_axi_pkg::*;
#(
    parameter logic [3:0] ID = 4'd0
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    state_t state, next;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic        aw_done, w_done;
    logic        unused_ok;
    logic        r_hs, b_hs, aw_fin, w_fin;

    assign unused_ok = ^{rid, rlast, bid, rresp[0], bresp[0]};

    assign addr_ok = state == IDLE;
    assign arvalid = state == RADDR;
    assign rready  = state == RDATA;
    assign awvalid = state == WREQ && !aw_done;
    assign wvalid  = state == WREQ && !w_done;
    assign bready  = state == WRESP;
    assign r_hs    = rready && rvalid;
    assign b_hs    = bready && bvalid;
    assign aw_fin  = aw_done || awready;
    assign w_fin   = w_done || wready;

    assign arid    = ID;
    assign awid    = ID;
    assign wid     = ID;
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign arsize  = axi_size(size_q);
    assign awsize  = axi_size(size_q);
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = BURST_INCR;
    assign awburst = BURST_INCR;
    assign arlock  = 2'd0;
    assign awlock  = 2'd0;
    assign arcache = 4'd0;
    assign awcache = 4'd0;
    assign arprot  = 3'd0;
    assign awprot  = 3'd0;
    assign axi_wdata = wdata_q;
    assign axi_wstrb = wstrb_q;
    assign wlast   = 1'b1;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = req ? (wr ? WREQ : RADDR) : IDLE;
            RADDR:   next = arready ? RDATA : RADDR;
            RDATA:   next = rvalid ? IDLE : RDATA;
            WREQ:    next = (aw_fin && w_fin) ? WRESP : WREQ;
            WRESP:   next = bvalid ? IDLE : WRESP;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            wstrb_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            data_ok <= 1'b0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            state   <= next;
            // done flags only live inside WREQ, so they are clear on every entry
            aw_done <= state == WREQ && aw_fin;
            w_done  <= state == WREQ && w_fin;
            data_ok <= r_hs || b_hs;
            err     <= r_hs ? rresp[1] : b_hs && bresp[1];
            if (r_hs)
                rdata <= axi_rdata;
            if (state == IDLE && req) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                size_q  <= size;
                wstrb_q <= wstrb;
            end
        end
    end
endmodule

// File: tb/tb_sram_axi_master.sv
// tb_sram_axi_master: directed self-checking bench for sram_axi_master
module tb_sram_axi_master;
    logic        aclk = 0, rst = 1;
    logic        req = 0, wr = 0;
    logic [1:0]  size = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic [3:0]  wstrb = 0;
    logic        addr_ok, data_ok, err;
    logic [31:0] rdata;
    logic [3:0]  arid, awid, wid;
    logic [31:0] araddr, awaddr, axi_wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic [3:0]  arcache, awcache, axi_wstrb;
    logic        arvalid, rready, awvalid, wlast, wvalid, bready;
    logic        arready = 0, rvalid = 0, rlast = 1, awready = 0, wready = 0, bvalid = 0;
    logic [3:0]  rid = 0, bid = 0;
    logic [31:0] axi_rdata = 0;
    logic [1:0]  rresp = 0, bresp = 0;
    logic [31:0] mem;
    int n_cmp = 0, n_err = 0;

    sram_axi_master dut (
        .aclk(aclk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .err(err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .axi_rdata(axi_rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state
        step();
        step();
        chk("rst_addr_ok", addr_ok, 1);
        chk("rst_data_ok", data_ok, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_valids", {arvalid, awvalid, wvalid}, 0);
        chk("rst_readies", {rready, bready}, 0);
        chk("const_len", {arlen, awlen}, 0);
        chk("const_burst", {arburst, awburst}, 4'b0101);
        chk("const_misc", {arlock, awlock, arcache, awcache, arprot, awprot, arid, awid, wid}, 0);
        chk("const_wlast", wlast, 1);
        rst = 0;
        step();

        // read, zero wait
        req = 1; wr = 0; addr = 32'h1FE001E0; size = 2;
        chk("rd_accept", addr_ok, 1);
        step();
        req = 0;
        chk("rd_arvalid", arvalid, 1);
        chk("rd_araddr", araddr, 32'h1FE001E0);
        chk("rd_arsize", arsize, 2);
        chk("rd_busy", addr_ok, 0);
        arready = 1;
        step();
        arready = 0;
        chk("rd_arvalid_drop", arvalid, 0);
        chk("rd_rready", rready, 1);
        rvalid = 1; axi_rdata = 32'hDEADBEEF; rresp = 2'b00;
        step();
        rvalid = 0;
        chk("rd_data_ok", data_ok, 1);
        chk("rd_rdata", rdata, 32'hDEADBEEF);
        chk("rd_err", err, 0);
        chk("rd_addr_ok_done", addr_ok, 1);
        step();
        chk("rd_pulse_end", data_ok, 0);
        chk("rd_rdata_hold", rdata, 32'hDEADBEEF);

        // write, W before AW
        req = 1; wr = 1; addr = 32'h100; size = 0; wdata = 32'hA5; wstrb = 4'b0001;
        step();
        req = 0;
        chk("wr_awvalid", awvalid, 1);
        chk("wr_wvalid", wvalid, 1);
        chk("wr_awsize", awsize, 0);
        chk("wr_wstrb", axi_wstrb, 4'b0001);
        chk("wr_wdata", axi_wdata, 32'hA5);
        chk("wr_awaddr", awaddr, 32'h100);
        wready = 1;
        step();
        wready = 0;
        chk("wr_wvalid_drop", wvalid, 0);
        chk("wr_awvalid_held", awvalid, 1);
        step();
        chk("wr_awvalid_held2", awvalid, 1);
        chk("wr_no_bready", bready, 0);
        awready = 1;
        step();
        awready = 0;
        chk("wr_awvalid_drop", awvalid, 0);
        chk("wr_bready", bready, 1);
        chk("wr_no_early_ok", data_ok, 0);
        bvalid = 1; bresp = 2'b00;
        step();
        bvalid = 0;
        chk("wr_data_ok", data_ok, 1);
        chk("wr_err", err, 0);
        chk("wr_rdata_kept", rdata, 32'hDEADBEEF);
        step();
        chk("wr_pulse_end", data_ok, 0);

        // error response on read
        req = 1; wr = 0; addr = 32'h200; size = 2;
        step();
        req = 0;
        arready = 1;
        step();
        arready = 0;
        rvalid = 1; rresp = 2'b10; axi_rdata = 32'h12345678;
        step();
        rvalid = 0; rresp = 2'b00;
        chk("er_data_ok", data_ok, 1);
        chk("er_err", err, 1);
        step();
        chk("er_err_end", {data_ok, err}, 0);

        // backpressure on AR with a second request waiting
        req = 1; wr = 0; addr = 32'h300; size = 1;
        step();
        wr = 1; addr = 32'h400; size = 3; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            chk("bp_arvalid", arvalid, 1);
            chk("bp_araddr", araddr, 32'h300);
            chk("bp_arsize", arsize, 1);
            chk("bp_addr_ok", addr_ok, 0);
            step();
        end
        arready = 1;
        step();
        arready = 0;
        chk("bp_rdata_state", {rready, addr_ok, awvalid}, 3'b100);
        rvalid = 1; axi_rdata = 32'h55AA;
        step();
        rvalid = 0;
        chk("bp_data_ok", data_ok, 1);
        chk("bp_accept_now", addr_ok, 1);
        step();
        req = 0;
        chk("bp_second_aw", awvalid, 1);
        chk("bp_second_addr", awaddr, 32'h400);
        chk("bp_size3", awsize, 3'b010);
        awready = 1; wready = 1;
        step();
        awready = 0; wready = 0;
        bvalid = 1;
        step();
        bvalid = 0;
        chk("bp_second_done", data_ok, 1);

        // back-to-back write then read of same address
        req = 1; wr = 1; addr = 32'h500; size = 2; wdata = 32'h11223344; wstrb = 4'hF;
        step();
        req = 0;
        awready = 1; wready = 1;
        mem = axi_wdata;
        step();
        awready = 0; wready = 0;
        bvalid = 1;
        step();
        bvalid = 0;
        chk("b2b_wr_ok", data_ok, 1);
        req = 1; wr = 0; addr = 32'h500;
        chk("b2b_addr_ok", addr_ok, 1);
        step();
        req = 0;
        chk("b2b_c1_ok", data_ok, 0);
        chk("b2b_araddr", araddr, 32'h500);
        arready = 1;
        step();
        arready = 0;
        chk("b2b_c2_ok", data_ok, 0);
        rvalid = 1; axi_rdata = mem;
        step();
        rvalid = 0;
        chk("b2b_c3_ok", data_ok, 1);
        chk("b2b_rdata", rdata, 32'h11223344);

        // reset in the middle of a write
        step();
        req = 1; wr = 1; addr = 32'h700; wdata = 32'h77;
        step();
        req = 0;
        chk("mr_awvalid", awvalid, 1);
        rst = 1;
        #1;
        chk("mr_valids", {awvalid, wvalid}, 0);
        chk("mr_data_ok", data_ok, 0);
        chk("mr_addr_ok", addr_ok, 1);
        step();
        rst = 0;
        step();
        req = 1; wr = 0; addr = 32'h600; size = 2;
        step();
        req = 0;
        chk("mr_rd_araddr", araddr, 32'h600);
        arready = 1;
        step();
        arready = 0;
        rvalid = 1; axi_rdata = 32'h0BADF00D;
        step();
        rvalid = 0;
        chk("mr_rd_ok", data_ok, 1);
        chk("mr_rd_data", rdata, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
